// File: rtl/obi_irq_cfg_mgr_pkg.sv
// Shared definitions for the interrupt-configuration halfword and its placement
// in the OBI register map. The interrupt controller imports the same package, so
// the field layout and line-to-lane mapping have a single definition.
//   irq_cfg_t     : per-line configuration halfword layout
//   mgr_state_e   : manager FSM states
//   cfg_word_addr : line index -> word byte address
//   cfg_lane_be   : 2-bit halfword enable -> 4-bit lane enable for a line
//   cfg_lane_sel  : extract a line's halfword from a 32-bit word
package obi_irq_cfg_mgr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mgr_state_e;

  // Two lines share one word; this is one line's halfword.
  typedef struct packed {
    logic [7:0] prio;   // zero-extended priority
    logic [1:0] rsvd;
    logic       nest;
    logic       heti;
    logic [1:0] trig;
    logic       ip;
    logic       ie;
  } irq_cfg_t;

  function automatic logic [31:0] cfg_word_addr(input logic [31:0] base,
                                                input logic [31:0] line);
    return base + ((line >> 1) << 2);
  endfunction

  function automatic logic [3:0] cfg_lane_be(input logic odd, input logic [1:0] be);
    return odd ? {be, 2'b00} : {2'b00, be};
  endfunction

  function automatic logic [15:0] cfg_lane_sel(input logic odd, input logic [31:0] word);
    return odd ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/obi_bus.sv
// Minimal OBI interface (32-bit address/data) with manager and subordinate views.
//   Manager     : drives req/addr/we/be/wdata/rready, receives gnt/rvalid/rdata/err
//   Subordinate : the mirror image
interface OBI_BUS;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        err;

  modport Manager (
    output req, addr, we, be, wdata, rready,
    input  gnt, rvalid, rdata, err
  );

  modport Subordinate (
    input  req, addr, we, be, wdata, rready,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/obi_irq_cfg_mgr.sv
// OBI manager that reads/writes per-line interrupt configuration halfwords and
// can sweep one halfword into every line.
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   obi_mgr                 : OBI manager port (one outstanding transaction)
//   cmd_valid_i/cmd_ready_o : command handshake; cmd_we_i/line/be/data describe it
//   init_i, init_cfg_i      : start a sweep writing init_cfg_i to all lines
//   rsp_valid_o/data/err    : one-cycle response pulse per transaction
//   busy_o                  : a transaction or sweep is in progress
//   init_done_o             : pulses with the response of the last sweep line
module obi_irq_cfg_mgr
  import obi_irq_cfg_mgr_pkg::*;
#(
  parameter int unsigned NrIrqLines = 64,
  parameter int unsigned NrIrqPrios = 32,
  parameter logic [31:0] BaseAddr   = 32'h0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  OBI_BUS.Manager                       obi_mgr,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_we_i,
  input  logic [$clog2(NrIrqLines)-1:0] cmd_line_i,
  input  logic [1:0]                    cmd_be_i,
  input  logic [15:0]                   cmd_data_i,
  input  logic                          init_i,
  input  logic [15:0]                   init_cfg_i,
  output logic                          rsp_valid_o,
  output logic [15:0]                   rsp_data_o,
  output logic                          rsp_err_o,
  output logic                          busy_o,
  output logic                          init_done_o
);

  localparam int unsigned LineWidth = $clog2(NrIrqLines);
  localparam int unsigned PrioWidth = $clog2(NrIrqPrios);
  localparam logic [7:0]  PrioMask  = 8'((32'd1 << PrioWidth) - 32'd1);
  localparam logic [LineWidth-1:0] LastLine = LineWidth'(NrIrqLines - 1);

  // Priority is PrioWidth bits wide; bits above it are forced to zero.
  function automatic irq_cfg_t clamp_prio(input logic [15:0] half);
    irq_cfg_t cfg;
    cfg      = irq_cfg_t'(half);
    cfg.prio = cfg.prio & PrioMask;
    return cfg;
  endfunction

  mgr_state_e           state_q, state_d;
  logic [LineWidth-1:0] line_q, line_d;
  logic                 we_q, we_d;
  logic [1:0]           be_q, be_d;
  irq_cfg_t             data_q, data_d;
  logic                 sweep_q, sweep_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [15:0]          rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 init_done_q, init_done_d;
  logic                 sweep_more_s;

  // A sweep continues until the last line has responded.
  assign sweep_more_s = sweep_q && (line_q != LastLine);

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      line_q      <= LineWidth'(0);
      we_q        <= 1'b0;
      be_q        <= 2'b00;
      data_q      <= irq_cfg_t'(16'h0000);
      sweep_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      we_q        <= we_d;
      be_q        <= be_d;
      data_q      <= data_d;
      sweep_q     <= sweep_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      init_done_q <= init_done_d;
    end
  end

  // Next-state logic. rvalid is only honoured in RESP, so a stray response
  // while idle or requesting cannot complete anything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (init_i || cmd_valid_i) state_d = ST_REQ;
        else                       state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (obi_mgr.gnt) state_d = ST_RESP;
        else             state_d = ST_REQ;
      end
      ST_RESP: begin
        if (obi_mgr.rvalid) state_d = sweep_more_s ? ST_REQ : ST_IDLE;
        else                state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture, sweep sequencing and response registers.
  always_comb begin
    line_d      = line_q;
    we_d        = we_q;
    be_d        = be_q;
    data_d      = data_q;
    sweep_d     = sweep_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    init_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init_i) begin
          line_d  = LineWidth'(0);
          we_d    = 1'b1;
          be_d    = 2'b11;
          data_d  = clamp_prio(init_cfg_i);
          sweep_d = 1'b1;
        end else if (cmd_valid_i) begin
          line_d  = cmd_line_i;
          we_d    = cmd_we_i;
          be_d    = cmd_we_i ? cmd_be_i : 2'b11;
          data_d  = clamp_prio(cmd_data_i);
          sweep_d = 1'b0;
        end else begin
          sweep_d = 1'b0;
        end
      end
      ST_RESP: begin
        if (obi_mgr.rvalid) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = we_q ? 16'h0000 : cfg_lane_sel(line_q[0], obi_mgr.rdata);
          rsp_err_d   = obi_mgr.err;
          if (sweep_more_s) begin
            line_d = line_q + LineWidth'(1);
          end else begin
            sweep_d     = 1'b0;
            init_done_d = sweep_q;
          end
        end else begin
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Bus and status outputs, all derived from registered state.
  assign obi_mgr.req    = (state_q == ST_REQ);
  assign obi_mgr.addr   = cfg_word_addr(BaseAddr, 32'(line_q));
  assign obi_mgr.we     = we_q;
  assign obi_mgr.be     = cfg_lane_be(line_q[0], be_q);
  assign obi_mgr.wdata  = {data_q, data_q};
  assign obi_mgr.rready = 1'b1;

  assign cmd_ready_o = (state_q == ST_IDLE) && !init_i;
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_obi_irq_cfg_mgr.sv
module tb_obi_irq_cfg_mgr;

  localparam int unsigned LINES    = 64;
  localparam int unsigned PRIOS    = 32;
  localparam logic [31:0] BASE     = 32'h4000_0100;
  localparam int          ERR_WORD = 10;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_we_i, init_i;
  logic [5:0]  cmd_line_i;
  logic [1:0]  cmd_be_i;
  logic [15:0] cmd_data_i, init_cfg_i;
  logic        cmd_ready_o, rsp_valid_o, rsp_err_o, busy_o, init_done_o;
  logic [15:0] rsp_data_o;

  OBI_BUS obi();

  obi_irq_cfg_mgr #(.NrIrqLines(LINES), .NrIrqPrios(PRIOS), .BaseAddr(BASE)) dut (
    .clk_i(clk), .rst_i(rst_i), .obi_mgr(obi),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_line_i(cmd_line_i), .cmd_be_i(cmd_be_i), .cmd_data_i(cmd_data_i),
    .init_i(init_i), .init_cfg_i(init_cfg_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o), .init_done_o(init_done_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- subordinate memory with configurable grant wait ----------
  logic [31:0] sub_mem [32] = '{2: 32'h0000_0A13, default: 32'h0};
  int          gnt_delay = 0;
  int          gnt_wait  = 0;
  logic        rvalid_q = 1'b0, err_q = 1'b0;
  logic [31:0] rdata_q = 32'h0;
  logic        hold_rvalid = 1'b0, inject_rvalid = 1'b0;
  logic [4:0]  sub_word;

  assign sub_word   = 5'((obi.addr - BASE) >> 2);
  assign obi.gnt    = obi.req && (gnt_wait == 0);
  assign obi.rvalid = rvalid_q | inject_rvalid;
  assign obi.rdata  = rdata_q;
  assign obi.err    = err_q;

  always @(posedge clk) begin
    if (!obi.req || obi.gnt) gnt_wait <= gnt_delay;
    else                     gnt_wait <= gnt_wait - 1;
    rvalid_q <= 1'b0;
    if (obi.req && obi.gnt) begin
      if (obi.we) begin
        for (int b = 0; b < 4; b++)
          if (obi.be[b]) sub_mem[sub_word][8*b +: 8] <= obi.wdata[8*b +: 8];
      end
      rdata_q  <= sub_mem[sub_word];
      err_q    <= (int'(sub_word) == ERR_WORD);
      rvalid_q <= !hold_rvalid;
    end
  end

  // ---------------- behavioural model: expected bus ops and responses --------
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;
  typedef struct packed {
    logic [15:0] data;
    logic        err;
    logic        last;
  } rsp_t;

  bus_t        exp_bus [$];
  rsp_t        exp_rsp [$];
  logic [15:0] model_cfg [64] = '{4: 16'h0A13, default: 16'h0};

  task automatic model_txn(input logic we, input int line, input logic [1:0] be,
                           input logic [15:0] data, input logic last);
    bus_t        b;
    rsp_t        r;
    logic [15:0] h;
    logic [1:0]  half_en;
    h       = {data[15:8] & 8'(PRIOS - 1), data[7:0]};
    half_en = we ? be : 2'b11;
    b.addr  = BASE + 32'((line / 2) * 4);
    b.we    = we;
    b.be    = 4'({2'b00, half_en} << (2 * (line % 2)));
    b.wdata = {h, h};
    r.data  = we ? 16'h0000 : model_cfg[line];
    r.err   = ((line / 2) == ERR_WORD);
    r.last  = last;
    if (we && be[0]) model_cfg[line][7:0]  = h[7:0];
    if (we && be[1]) model_cfg[line][15:8] = h[15:8];
    exp_bus.push_back(b);
    exp_rsp.push_back(r);
  endtask

  // ---------------- per-cycle compare process --------------------------------
  int          gnt_count = 0;
  int          done_count = 0;
  int          done_cyc = 0;
  logic [31:0] last_gnt_addr = 32'h0;

  initial begin
    bus_t e;
    rsp_t r;
    logic pw = 1'b0;
    bus_t prev;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        pw = 1'b0;
      end else begin
        check("rready", obi.rready, 1'b1);
        if (obi.req && pw) begin
          check("hold_addr", obi.addr, prev.addr);
          check("hold_we", obi.we, prev.we);
          check("hold_be", obi.be, prev.be);
          check("hold_wdata", obi.wdata, prev.wdata);
        end
        if (obi.req && obi.gnt) begin
          gnt_count++;
          last_gnt_addr = obi.addr;
          if (exp_bus.size() == 0) begin
            check("bus_unexpected", 1'b1, 1'b0);
          end else begin
            e = exp_bus.pop_front();
            check("bus_addr", obi.addr, e.addr);
            check("bus_we", obi.we, e.we);
            check("bus_be", obi.be, e.be);
            if (e.we) check("bus_wdata", obi.wdata, e.wdata);
          end
        end
        pw = obi.req && !obi.gnt;
        prev.addr = obi.addr; prev.we = obi.we; prev.be = obi.be; prev.wdata = obi.wdata;
        if (rsp_valid_o) begin
          if (exp_rsp.size() == 0) begin
            check("rsp_unexpected", 1'b1, 1'b0);
          end else begin
            r = exp_rsp.pop_front();
            check("rsp_data", rsp_data_o, r.data);
            check("rsp_err", rsp_err_o, r.err);
            check("init_done", init_done_o, r.last);
          end
        end else begin
          check("init_done_idle", init_done_o, 1'b0);
        end
        if (init_done_o) begin
          done_count++;
          done_cyc = cyc;
        end
        check("busy", busy_o, exp_rsp.size() != 0);
        check("cmd_ready", cmd_ready_o, (exp_rsp.size() == 0) && !init_i);
      end
    end
  end

  // ---------------- stimulus helpers -----------------------------------------
  task automatic issue(input logic we, input int line, input logic [1:0] be,
                       input logic [15:0] data, output int acc_cyc);
    int n = 0;
    cmd_we_i = we; cmd_line_i = 6'(line); cmd_be_i = be; cmd_data_i = data;
    cmd_valid_i = 1'b1;
    acc_cyc = -1;
    @(negedge clk);
    while (!cmd_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_o) begin
      check("accept_timeout", 1'b0, 1'b1);
      cmd_valid_i = 1'b0;
    end else begin
      @(posedge clk);
      acc_cyc = cyc;
      model_txn(we, line, be, data, 1'b0);
      #1 cmd_valid_i = 1'b0;
    end
  endtask

  task automatic wait_rsp(output int c);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid_o) check("rsp_timeout", 1'b0, 1'b1);
    c = cyc;
  endtask

  // ---------------- directed sequence ----------------------------------------
  initial begin
    int a, c, n, g0;
    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_line_i = 6'd0; cmd_be_i = 2'b00;
    cmd_data_i = 16'h0; init_i = 1'b0; init_cfg_i = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", obi.req, 1'b0);
    check("rst_ready", cmd_ready_o, 1'b1);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_rsp_data", rsp_data_o, 16'h0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_init_done", init_done_o, 1'b0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Write line 5: upper half of word 2, latency 3.
    issue(1'b1, 5, 2'b11, 16'h0701, a);
    check("w5_req", obi.req, 1'b1);
    check("w5_addr", obi.addr, BASE + 32'd8);
    check("w5_be", obi.be, 4'b1100);
    check("w5_wdata", obi.wdata, 32'h0701_0701);
    wait_rsp(c);
    check("w5_latency", 32'(c - a), 32'd3);
    @(negedge clk);
    check("w5_pulse_once", rsp_valid_o, 1'b0);

    // Read line 4 (low half) and line 5 (high half) of the same word.
    @(posedge clk); #1;
    issue(1'b0, 4, 2'b00, 16'h0, a);
    check("r4_be", obi.be, 4'b0011);
    wait_rsp(c);
    check("r4_data", rsp_data_o, 16'h0A13);
    @(posedge clk); #1;
    issue(1'b0, 5, 2'b00, 16'h0, a);
    wait_rsp(c);
    check("r5_data", rsp_data_o, 16'h0701);

    // Grant withheld 3 cycles: req held 4 cycles, one transaction.
    gnt_delay = 3;
    @(posedge clk); #1;
    g0 = gnt_count;
    issue(1'b1, 2, 2'b01, 16'h1234, a);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (obi.req) n++;
      else break;
    end
    check("wait_req_cycles", 32'(n), 32'd4);
    wait_rsp(c);
    check("wait_latency", 32'(c - a), 32'd6);
    check("wait_single_gnt", 32'(gnt_count - g0), 32'd1);
    gnt_delay = 0;

    // Prio-only write on odd line 7, read back; error word read.
    @(posedge clk); #1;
    issue(1'b1, 7, 2'b10, 16'h1FAA, a);
    wait_rsp(c);
    @(posedge clk); #1;
    issue(1'b0, 7, 2'b00, 16'h0, a);
    wait_rsp(c);
    check("r7_data", rsp_data_o, 16'h1F00);
    @(posedge clk); #1;
    issue(1'b0, 21, 2'b00, 16'h0, a);
    wait_rsp(c);
    check("r21_err", rsp_err_o, 1'b1);

    // Init sweep with a command held pending throughout.
    @(posedge clk); #1;
    g0 = gnt_count;
    init_cfg_i = 16'h0001;
    init_i = 1'b1;
    @(posedge clk);
    for (int l = 0; l < LINES; l++) model_txn(1'b1, l, 2'b11, 16'h0001, l == LINES - 1);
    #1 init_i = 1'b0;
    issue(1'b0, 9, 2'b00, 16'h0, a);
    check("sweep_gnts", 32'(gnt_count - g0), 32'd64);
    check("sweep_last_addr", last_gnt_addr, BASE + 32'd124);
    check("sweep_done_count", 32'(done_count), 32'd1);
    check("held_cmd_after_done", 32'(a >= done_cyc), 32'd1);
    wait_rsp(c);
    check("r9_after_sweep", rsp_data_o, 16'h0001);

    // Reset while waiting for the response; late rvalid must be ignored.
    hold_rvalid = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 12, 2'b11, 16'h0305, a);
    n = 0;
    @(negedge clk);
    while (!(busy_o && !obi.req) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_resp", 32'(busy_o && !obi.req), 32'd1);
    #2 rst_i = 1'b1;
    exp_bus.delete();
    exp_rsp.delete();
    #1;
    check("mid_rst_req", obi.req, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_ready", cmd_ready_o, 1'b1);
    check("mid_rst_rsp_valid", rsp_valid_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    hold_rvalid = 1'b0;
    inject_rvalid = 1'b1;
    @(posedge clk); #1 inject_rvalid = 1'b0;
    @(negedge clk);
    check("late_rvalid_ignored", rsp_valid_o, 1'b0);
    check("late_rvalid_idle", busy_o, 1'b0);
    @(posedge clk); #1;
    issue(1'b0, 12, 2'b00, 16'h0, a);
    wait_rsp(c);
    check("after_rst_data", rsp_data_o, 16'h0305);
    check("after_rst_latency", 32'(c - a), 32'd3);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/obi_irq_cfg_mgr.md
OBI_IRQ_CFG_MGR -- requirements
Module: obi_irq_cfg_mgr

Interface
REQ-001 SHALL have parameter NrIrqLines, default 64, number of interrupt lines in the target controller.
REQ-002 SHALL have parameter NrIrqPrios, default 32, number of priority levels; PrioWidth = clog2(NrIrqPrios) SHALL be derived.
REQ-003 SHALL have parameter BaseAddr, default 32'h0, OBI byte address of the line-0/1 register word.
REQ-004 SHALL have ports, in order:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- obi_mgr  OBI_BUS.Manager  -  req/addr/we/be/wdata out; gnt/rvalid/rdata/err in; rready driven 1.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_line_i  in  clog2(NrIrqLines)  target line index.
- cmd_be_i  in  2  [1] = prio byte, [0] = flag byte; writes only.
- cmd_data_i  in  16  [15:8] prio (zero-extended), [5] nest, [4] heti, [3:2] trig, [1] ip, [0] ie.
- init_i  in  1  pulse: start init sweep.
- init_cfg_i  in  16  halfword written to every line during the sweep.
- rsp_valid_o  out  1  one-cycle pulse per completed transaction.
- rsp_data_o  out  16  read halfword (zero for writes).
- rsp_err_o  out  1  OBI err of that transaction.
- busy_o  out  1  FSM not IDLE.
- init_done_o  out  1  one-cycle pulse after the last sweep response.

Function
REQ-005 Address mapping SHALL be addr = BaseAddr + (line >> 1)*4; line[0]=0 selects bytes [1:0], line[0]=1 selects bytes [3:2].
REQ-006 Write be SHALL be cmd_be_i placed in the selected half (other half 0); wdata SHALL replicate the halfword into both halves.
REQ-007 Read be SHALL be 2'b11 in the selected half; rsp_data_o SHALL be rdata[15:0] for even lines and rdata[31:16] for odd lines.
REQ-008 FSM states SHALL be IDLE, REQ, RESP.
REQ-009 IDLE: cmd_ready_o = 1 only in IDLE with init_i low; a handshake SHALL register the command and go to REQ next cycle.
REQ-010 init_i in IDLE SHALL take priority over cmd_valid_i, clear the line counter and enter REQ with a write of init_cfg_i, be 2'b11.
REQ-011 REQ: req SHALL be 1 with addr/we/be/wdata stable until gnt; on gnt go to RESP, req drops the following cycle.
REQ-012 RESP: on rvalid, rsp_valid_o SHALL pulse with data/err; return to IDLE, or during a sweep increment the line counter and re-enter REQ.
REQ-013 Exactly one transaction SHALL be outstanding; gnt and rvalid in the same cycle as req SHALL be legal and SHALL still produce RESP-state latency of one cycle minimum.
REQ-014 Sweep SHALL end after line NrIrqLines-1 responds (no counter wrap); init_done_o SHALL pulse in that response cycle; rsp_err_o during a sweep SHALL not abort it.
REQ-015 init_i or cmd_valid_i while busy SHALL be ignored (cmd_ready_o = 0).
REQ-016 Minimum command-to-response latency SHALL be 3 cycles (accept, REQ, RESP) with zero-wait subordinate.

Reset
REQ-017 rst_i SHALL asynchronously force IDLE, req = 0, cmd_ready_o = 1, rsp_valid_o = 0, rsp_data_o = 0, rsp_err_o = 0, busy_o = 0, init_done_o = 0, line counter = 0.
REQ-018 Reset mid-transaction SHALL abandon it; a late rvalid after reset release in IDLE SHALL be ignored.

Structure
REQ-019 The halfword layout (field offsets) and the line-to-address/be mapping function SHALL live in a shared package also used by the interrupt controller.
REQ-020 Implementation SHALL be a single module; no sub-module.

Verification
REQ-021 Write line 5, be 2'b11, data 16'h0701 -> addr BaseAddr+8, be 4'b1100, wdata 32'h07010701, rsp_valid one pulse.
REQ-022 Read line 4, subordinate rdata 32'h0000_0A13 -> be 4'b0011, rsp_data_o 16'h0A13.
REQ-023 gnt withheld 3 cycles -> req and addr/be/wdata held constant for 4 cycles, single transaction.
REQ-024 init_i with NrIrqLines=64, init_cfg_i 16'h0001 -> 64 writes at addrs BaseAddr..BaseAddr+124, alternating be 4'b0011/4'b1100, init_done_o after the 64th rvalid.
REQ-025 rst_i asserted in RESP -> req 0, busy_o 0 immediately; following command completes normally.
REQ-026 cmd_valid_i held during sweep -> cmd_ready_o 0 until sweep done, then accepted.
